// File: rtl/csram_ctrl_pkg.sv
// Shared definitions for the csram access controller: bus widths, FSM encoding,
// grant identifiers and the wait-state limit.
package csram_ctrl_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int WAIT_STATES_MAX = 7;
  localparam int CNT_W           = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  // Out-of-range wait-state settings saturate to the legal 0..7 window.
  function automatic logic [CNT_W-1:0] clamp_wait(input int ws);
    if (ws > WAIT_STATES_MAX) return CNT_W'(WAIT_STATES_MAX);
    if (ws < 0)               return '0;
    return CNT_W'(ws);
  endfunction

endpackage

// File: rtl/csram_ctrl_if.sv
// Requester-side and memory-side signals of the csram controller; the slave
// modport is the controller, the master modport is whatever surrounds it.
interface csram_ctrl_if;
  import csram_ctrl_pkg::*;

  logic              in_fetch_req;
  logic [ADDR_W-1:0] in_fetch_address;
  logic              out_fetch_ack;
  logic [DATA_W-1:0] out_fetch_data;

  logic              in_data_req;
  logic              in_data_write;
  logic [ADDR_W-1:0] in_data_address;
  logic [DATA_W-1:0] in_data_wdata;
  logic              out_data_ack;
  logic [DATA_W-1:0] out_data_rdata;

  logic [ADDR_W-1:0] out_sram_address;
  logic [DATA_W-1:0] out_sram_data;
  logic              out_sram_write_enable;
  logic              out_sram_output_enable;
  logic [DATA_W-1:0] in_sram_data;

  logic              out_busy;

  modport slave (
    input  in_fetch_req, in_fetch_address,
    output out_fetch_ack, out_fetch_data,
    input  in_data_req, in_data_write, in_data_address, in_data_wdata,
    output out_data_ack, out_data_rdata,
    output out_sram_address, out_sram_data, out_sram_write_enable, out_sram_output_enable,
    input  in_sram_data,
    output out_busy
  );

  modport master (
    output in_fetch_req, in_fetch_address,
    input  out_fetch_ack, out_fetch_data,
    output in_data_req, in_data_write, in_data_address, in_data_wdata,
    input  out_data_ack, out_data_rdata,
    input  out_sram_address, out_sram_data, out_sram_write_enable, out_sram_output_enable,
    output in_sram_data,
    input  out_busy
  );

endinterface

// File: rtl/csram_ctrl.sv
// Arbitrating access controller in front of the combinational csram: registers the
// memory inputs, holds them for WAIT_STATES extra cycles, then captures and acks.
module csram_ctrl
  import csram_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  csram_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = clamp_wait(WAIT_STATES);

  state_t            r_state;
  state_t            w_state_nxt;
  grant_t            r_grant;
  grant_t            r_last;
  logic [CNT_W-1:0]  r_cnt;

  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_data;
  logic              r_sram_we;
  logic              r_sram_oe;

  logic              r_fetch_ack;
  logic              r_data_ack;
  logic [DATA_W-1:0] r_fetch_data;
  logic [DATA_W-1:0] r_data_rdata;

  logic              w_grant_en;
  grant_t            w_grant;
  logic              w_write;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_capture;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_grant     = GRANT_DATA;
    w_write     = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_fetch_req || bus.in_data_req) begin
          w_grant_en  = 1'b1;
          w_state_nxt = ACCESS;
          // On contention the port that lost last time wins, so neither can starve.
          if (bus.in_fetch_req && (!bus.in_data_req || r_last == GRANT_DATA))
            w_grant = GRANT_FETCH;
          if (w_grant == GRANT_FETCH) begin
            w_addr = bus.in_fetch_address;
          end else begin
            w_addr  = bus.in_data_address;
            w_write = bus.in_data_write;
            w_wdata = bus.in_data_wdata;
          end
        end
      end
      ACCESS: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= GRANT_FETCH;
      r_last       <= GRANT_FETCH;
      r_cnt        <= '0;
      r_sram_addr  <= '0;
      r_sram_data  <= '0;
      r_sram_we    <= 1'b0;
      r_sram_oe    <= 1'b0;
      r_fetch_ack  <= 1'b0;
      r_data_ack   <= 1'b0;
      r_fetch_data <= '0;
      r_data_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_ack <= 1'b0;
      r_data_ack  <= 1'b0;
      if (w_grant_en) begin
        r_grant     <= w_grant;
        r_cnt       <= CNT_INIT;
        r_sram_addr <= w_addr;
        r_sram_data <= w_wdata;
        r_sram_we   <= w_write;
        r_sram_oe   <= !w_write;
      end else if (w_capture) begin
        // Memory inputs return to zero once the result is captured.
        r_last      <= r_grant;
        r_sram_addr <= '0;
        r_sram_data <= '0;
        r_sram_we   <= 1'b0;
        r_sram_oe   <= 1'b0;
        if (r_grant == GRANT_FETCH) begin
          r_fetch_data <= bus.in_sram_data;
          r_fetch_ack  <= 1'b1;
        end else begin
          r_data_ack <= 1'b1;
          if (!r_sram_we) r_data_rdata <= bus.in_sram_data;
        end
      end else if (r_state == ACCESS) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign bus.out_fetch_ack          = r_fetch_ack;
  assign bus.out_fetch_data         = r_fetch_data;
  assign bus.out_data_ack           = r_data_ack;
  assign bus.out_data_rdata         = r_data_rdata;
  assign bus.out_sram_address       = r_sram_addr;
  assign bus.out_sram_data          = r_sram_data;
  assign bus.out_sram_write_enable  = r_sram_we;
  assign bus.out_sram_output_enable = r_sram_oe;
  assign bus.out_busy               = (r_state != IDLE);

endmodule

// File: tb/tb_csram_ctrl.sv
// Bench for csram_ctrl: a csram stand-in memory, an arbitration/memory reference model
// feeding a scoreboard queue, and a monitor that checks every ack and ACCESS cycle.
module tb_csram_ctrl;
  import csram_ctrl_pkg::*;

  localparam int WS = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;
  bit started = 1'b0;

  csram_ctrl_if bus  ();
  csram_ctrl_if bus0 ();
  csram_ctrl_if bus7 ();

  csram_ctrl #(.WAIT_STATES(WS)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  csram_ctrl #(.WAIT_STATES(0))  u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  csram_ctrl #(.WAIT_STATES(7))  u_dut7 (.clk(clk), .reset(reset), .bus(bus7));

  // csram stand-in: 4K mapped words, everything above reads as 0xFFFF.
  logic [15:0] mem [0:4095];

  function automatic logic [15:0] init_word(input int i);
    logic [31:0] v;
    if (i == 3) return 16'h1234;
    v = i * 40503 + 17;
    return v[15:0] ^ 16'hA5C3;
  endfunction

  assign bus.in_sram_data  = bus.out_sram_output_enable  ?
    ((bus.out_sram_address  < 16'h1000) ? mem[bus.out_sram_address[11:0]]  : 16'hFFFF) : 16'h0000;
  assign bus0.in_sram_data = bus0.out_sram_output_enable ?
    ((bus0.out_sram_address < 16'h1000) ? mem[bus0.out_sram_address[11:0]] : 16'hFFFF) : 16'h0000;
  assign bus7.in_sram_data = bus7.out_sram_output_enable ?
    ((bus7.out_sram_address < 16'h1000) ? mem[bus7.out_sram_address[11:0]] : 16'hFFFF) : 16'h0000;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.out_sram_write_enable && bus.out_sram_address < 16'h1000)
        mem[bus.out_sram_address[11:0]] = bus.out_sram_data;
    end
  end

  // Reference model state
  logic [15:0] ref_mem [0:4095];
  logic [15:0] ref_fd, ref_dd;
  bit          ref_last_fetch;

  function automatic logic [15:0] rd_ref(input logic [15:0] a);
    return (a < 16'h1000) ? ref_mem[a[11:0]] : 16'hFFFF;
  endfunction

  typedef struct {
    bit          is_fetch;
    int          ack_cyc;
    logic [15:0] addr;
    bit          wr;
    logic [15:0] wdata;
    logic [15:0] exp_fd;
    logic [15:0] exp_dd;
  } exp_t;

  exp_t sb[$];
  exp_t me;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each ack, checks memory drive during ACCESS.
  always @(negedge clk) begin
    if (started && !reset) begin
      if (sb.size() > 0 && cyc > sb[0].ack_cyc) begin
        me = sb.pop_front();
        check("ack_missing", 32'(cyc), 32'(me.ack_cyc));
      end
      if (bus.out_fetch_ack || bus.out_data_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", {30'b0, bus.out_fetch_ack, bus.out_data_ack}, 32'h0);
        end else begin
          me = sb.pop_front();
          check("ack_port", {30'b0, bus.out_fetch_ack, bus.out_data_ack}, me.is_fetch ? 32'h2 : 32'h1);
          check("ack_cycle", 32'(cyc), 32'(me.ack_cyc));
          check("fetch_data", 32'(bus.out_fetch_data), 32'(me.exp_fd));
          check("data_rdata", 32'(bus.out_data_rdata), 32'(me.exp_dd));
          check("done_enables", {30'b0, bus.out_sram_write_enable, bus.out_sram_output_enable}, 32'h0);
        end
      end else if (sb.size() > 0 && cyc >= sb[0].ack_cyc - 1 - WS && cyc < sb[0].ack_cyc) begin
        check("access_addr", 32'(bus.out_sram_address), 32'(sb[0].addr));
        check("access_we_oe", {30'b0, bus.out_sram_write_enable, bus.out_sram_output_enable},
              sb[0].wr ? 32'h2 : 32'h1);
        check("access_busy", 32'(bus.out_busy), 32'h1);
        if (sb[0].wr) check("access_wdata", 32'(bus.out_sram_data), 32'(sb[0].wdata));
      end else if (!bus.out_busy) begin
        check("idle_drive", {14'b0, bus.out_sram_write_enable, bus.out_sram_output_enable, bus.out_sram_address}, 32'h0);
      end
    end
  end

  // Issue one request group; all raised requests are held until n acks have occurred.
  task automatic do_txn(input bit fe, input logic [15:0] fa, input bit de, input bit dw,
                        input logic [15:0] da, input logic [15:0] dwd, input int n, input bit scramble);
    int   t, guard, last_ack;
    bit   gf;
    exp_t e;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (bus.out_busy && guard < 50);
    if (bus.out_busy) check("idle_wait_timeout", 32'(bus.out_busy), 32'h0);
    t = cyc;
    bus.in_fetch_req     = fe;
    bus.in_fetch_address = fa;
    bus.in_data_req      = de;
    bus.in_data_write    = dw;
    bus.in_data_address  = da;
    bus.in_data_wdata    = dwd;
    for (int k = 0; k < n; k++) begin
      gf = (fe && de) ? !ref_last_fetch : fe;
      e.is_fetch = gf;
      e.ack_cyc  = t + 2 + WS + k * (WS + 3);
      if (gf) begin
        e.addr = fa; e.wr = 1'b0; e.wdata = 16'h0;
        ref_fd = rd_ref(fa);
      end else begin
        e.addr = da; e.wr = dw; e.wdata = dwd;
        if (dw) begin
          if (da < 16'h1000) ref_mem[da[11:0]] = dwd;
        end else begin
          ref_dd = rd_ref(da);
        end
      end
      e.exp_fd = ref_fd;
      e.exp_dd = ref_dd;
      ref_last_fetch = gf;
      sb.push_back(e);
    end
    last_ack = t + 2 + WS + (n - 1) * (WS + 3);
    if (scramble) begin
      @(negedge clk);
      bus.in_fetch_address = 16'($urandom);
      bus.in_data_address  = 16'($urandom);
      bus.in_data_wdata    = 16'($urandom);
    end
    while (cyc < last_ack) @(negedge clk);
    bus.in_fetch_req = 1'b0;
    bus.in_data_req  = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 16'hFF00 | 16'($urandom_range(0, 255));
    if (r < 4)  return 16'($urandom_range(0, 31));
    return 16'($urandom_range(0, 4095));
  endfunction

  task automatic lat_test();
    int t, a0, a7;
    logic [15:0] exp;
    a0 = -1; a7 = -1;
    @(negedge clk);
    t = cyc;
    exp = rd_ref(16'h0003);
    bus0.in_data_req = 1'b1; bus0.in_data_write = 1'b0; bus0.in_data_address = 16'h0003;
    bus7.in_data_req = 1'b1; bus7.in_data_write = 1'b0; bus7.in_data_address = 16'h0003;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus0.out_data_ack) begin if (a0 < 0) a0 = cyc; bus0.in_data_req = 1'b0; end
      if (bus7.out_data_ack) begin if (a7 < 0) a7 = cyc; bus7.in_data_req = 1'b0; end
      if (cyc == t + 2) begin
        bus0.in_data_address = 16'h0005;
        bus7.in_data_address = 16'h0005;
      end
      if (cyc == t + 8) check("ws7_addr_hold", 32'(bus7.out_sram_address), 32'h0003);
    end
    bus0.in_data_req = 1'b0;
    bus7.in_data_req = 1'b0;
    check("ws0_ack_cycle", 32'(a0), 32'(t + 2));
    check("ws7_ack_cycle", 32'(a7), 32'(t + 9));
    check("ws0_rdata", 32'(bus0.out_data_rdata), 32'(exp));
    check("ws7_rdata", 32'(bus7.out_data_rdata), 32'(exp));
  endtask

  initial begin
    int t, sel, n, guard;
    bit fe, de, dw, scr;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    ref_fd = 16'h0; ref_dd = 16'h0; ref_last_fetch = 1'b1;
    bus.in_fetch_req = 1'b0;  bus.in_fetch_address = '0; bus.in_data_req = 1'b0;
    bus.in_data_write = 1'b0; bus.in_data_address = '0;  bus.in_data_wdata = '0;
    bus0.in_fetch_req = 1'b0; bus0.in_fetch_address = '0; bus0.in_data_req = 1'b0;
    bus0.in_data_write = 1'b0; bus0.in_data_address = '0; bus0.in_data_wdata = '0;
    bus7.in_fetch_req = 1'b0; bus7.in_fetch_address = '0; bus7.in_data_req = 1'b0;
    bus7.in_data_write = 1'b0; bus7.in_data_address = '0; bus7.in_data_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_acks", {30'b0, bus.out_fetch_ack, bus.out_data_ack}, 32'h0);
    check("rst_busy", 32'(bus.out_busy), 32'h0);
    check("rst_fetch_data", 32'(bus.out_fetch_data), 32'h0);
    check("rst_data_rdata", 32'(bus.out_data_rdata), 32'h0);
    check("rst_sram_addr_data", {bus.out_sram_address, bus.out_sram_data}, 32'h0);
    check("rst_enables", {30'b0, bus.out_sram_write_enable, bus.out_sram_output_enable}, 32'h0);
    started = 1'b1;

    do_txn(1'b1, 16'h0003, 1'b0, 1'b0, 16'h0, 16'h0, 1, 1'b0);
    do_txn(1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1, 1'b0);

    // Abort a read in its second ACCESS cycle.
    guard = 0;
    do begin @(negedge clk); guard++; end while (bus.out_busy && guard < 50);
    t = cyc;
    bus.in_data_req = 1'b1; bus.in_data_write = 1'b0; bus.in_data_address = 16'h0003;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_busy", 32'(bus.out_busy), 32'h1);
    reset = 1'b1;
    bus.in_data_req = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.out_busy), 32'h0);
    check("abort_acks", {30'b0, bus.out_fetch_ack, bus.out_data_ack}, 32'h0);
    check("abort_enables", {30'b0, bus.out_sram_write_enable, bus.out_sram_output_enable}, 32'h0);
    check("abort_rdregs", {bus.out_fetch_data, bus.out_data_rdata}, 32'h0);
    reset = 1'b0;
    ref_fd = 16'h0; ref_dd = 16'h0; ref_last_fetch = 1'b1;
    @(negedge clk);
    check("abort_no_late_ack", {30'b0, bus.out_fetch_ack, bus.out_data_ack}, 32'h0);

    do_txn(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0040, 16'h0, 4, 1'b0);
    do_txn(1'b0, 16'h0, 1'b1, 1'b0, 16'hFFF0, 16'h0, 1, 1'b0);
    do_txn(1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0, 1, 1'b1);

    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 2);
      fe  = (sel != 1);
      de  = (sel != 0);
      dw  = $urandom_range(0, 2) == 0;
      n   = (sel == 2) ? $urandom_range(1, 3) : 1;
      scr = (sel != 2) && ($urandom_range(0, 1) == 1);
      do_txn(fe, rand_addr(), de, dw, rand_addr(), 16'($urandom), n, scr);
    end

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin @(negedge clk); guard++; end
    if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'h0);

    lat_test();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1);
  end

endmodule

// File: doc/csram_ctrl.md
# csram_ctrl

Sequential access controller sitting directly upstream of the combinational `csram` program/data memory. It arbitrates between an instruction-fetch port and a data port, drives the memory's address, data and enable inputs from registers, holds them for a programmable number of wait states, then captures the memory output and returns it with a one-cycle acknowledge. This isolates requesters from the memory's deep combinational decode path.

## Interface
- `WAIT_STATES`, 1: extra cycles the memory inputs are held before read data is captured; legal range 0..7.
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_fetch_req`  in  1  fetch request, level; read only.
- `in_fetch_address`  in  16  fetch word address.
- `out_fetch_ack`  out  1  one-cycle pulse; `out_fetch_data` valid in this cycle.
- `out_fetch_data`  out  16  registered fetch read data; held until next fetch completes.
- `in_data_req`  in  1  data-port request, level.
- `in_data_write`  in  1  1 = write, 0 = read; sampled with request.
- `in_data_address`  in  16  data word address.
- `in_data_wdata`  in  16  write data.
- `out_data_ack`  out  1  one-cycle completion pulse.
- `out_data_rdata`  out  16  registered read data; unchanged by writes.
- `out_sram_address`  out  16  to memory `in_address`.
- `out_sram_data`  out  16  to memory `in_data`.
- `out_sram_write_enable`  out  1  to memory `in_write_enable`.
- `out_sram_output_enable`  out  1  to memory `in_output_enable`.
- `in_sram_data`  in  16  from memory `out_data`.
- `out_busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ACCESS, DONE. Reset forces IDLE.
- Reset values: all acks 0, `out_busy` 0, both read-data registers 0x0000, SRAM address/data 0x0000, both enables 0, wait counter 0, last-grant flag = fetch.
- IDLE: if only one request is high, grant it; if both are high, grant the port not granted last time. Otherwise grant data. Latch the granted port's address, write flag and wdata; set counter = `WAIT_STATES`; go ACCESS. With no request, stay in IDLE with SRAM outputs 0 and enables 0.
- ACCESS: drive latched address and wdata.
  - Read: `out_sram_output_enable`=1, `out_sram_write_enable`=0.
  - Write: `out_sram_write_enable`=1, `out_sram_output_enable`=0.
  - Counter decrements each cycle. When the counter is 0, capture `in_sram_data` into the granted port's read register (reads only), update last-grant, and go DONE.
- DONE: pulse the granted port's ack for exactly one cycle; enables 0; go IDLE.
- Request inputs and address changes are ignored outside IDLE because the request was latched at grant.
- Requester rule: deassert req at the edge following ack. A req still high in IDLE is a new request.
- Unmapped reads return whatever the memory produces, normally 0xFFFF. The controller does not alter the data.
- Write completion: `out_data_rdata` holds its previous value.

## Timing
- Request sampled in IDLE at cycle t. ACCESS occupies cycles t+1 .. t+1+`WAIT_STATES`. Ack is high at cycle t+2+`WAIT_STATES`. Next grant is possible at t+3+`WAIT_STATES`.
- `WAIT_STATES`=0 gives a 3-cycle transaction with ack at t+2.
- Memory inputs are stable from the first ACCESS cycle through capture; no glitches mid-transaction.
- Reset asserted in any state: IDLE on the next edge, no ack emitted, enables 0 on that edge. Read registers clear to 0x0000.
- Both requests arriving back-to-back alternate grants. Neither port can be starved for more than one transaction.

## Structure
- Shared package holds:
  - ADDR_W=16 and DATA_W=16
  - state encoding IDLE/ACCESS/DONE
  - grant-select constants GRANT_FETCH/GRANT_DATA
  - WAIT_STATES maximum (7)
- No sub-module. The controller does not instantiate `csram`; the top level wires them together. The bench instantiates both.

## Test plan
- Fetch read at 0x0003 with `WAIT_STATES`=1 (`csram` program at that address = 0x1234): `out_fetch_ack` at t+3, `out_fetch_data`=0x1234, output_enable high for cycles t+1..t+2.
- Data write of 0xBEEF to 0x0040: write_enable high during ACCESS with `out_sram_data`=0xBEEF. `out_data_ack` at t+3, `out_data_rdata` unchanged (0x0000 after reset).
- Both requests high continuously for 4 transactions: grant order data, fetch, data, fetch (last-grant resets to fetch); each ack separated by 4 cycles.
- Read of unmapped address 0xFFF0: `out_data_rdata`=0xFFFF.
- Reset asserted in second ACCESS cycle: next cycle IDLE, no ack, enables 0, `out_busy` 0, read registers 0x0000.
- `WAIT_STATES`=0 and 7: ack at exactly t+2 and t+9 respectively. Address change during ACCESS has no effect on `out_sram_address`.
